div_unit: RTL and testbench

Serial 32-bit integer divider executing RV32M DIV/DIVU/REM/REMU. Sits directly downstream of the dispatcher. It consumes `dispatcher_div_inf` and pulses `div_done` back, which releases the dispatcher's `div_stall`. Each result is handed to write-back over a valid/ready handshake. The unit holds one operation at a time and computes it with a radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/div_unit.sv | 192 +++++++++++++++++++
 tb/tb_div_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Serial radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one operation in flight.
// Latency: 33 cycles from accept to div_wb_valid; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: the result is held in DONE until div_wb_ready; no new accept until RECOVER has passed.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               abandons any operation in progress; no result is produced
//   dispatcher_div_inf  instruction_valid, div_control, rd, rs1, rs2 from the dispatcher
//   div_wb_ready        write-back accepts the result this cycle
//   div_wb_valid/_rd/_result  registered result, stable until the handshake
//   div_done            pulse in the handshake cycle (releases the dispatcher stall)
//   div_busy            high in every state except IDLE

package div_pkg;
    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_t;

    typedef struct packed {
        logic    instruction_valid;
        div_op_t div_control;
    } div_ctrl_t;

    typedef struct packed {
        div_ctrl_t             ctrl;
        logic [4:0]            rd;
        logic [DIV_XLEN-1:0]   rs1;
        logic [DIV_XLEN-1:0]   rs2;
    } dispatcher_div_inf_t;
endpackage

module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  dispatcher_div_inf_t dispatcher_div_inf,
    input  logic                div_wb_ready,
    output logic                div_wb_valid,
    output logic [4:0]          div_wb_rd,
    output logic [XLEN-1:0]     div_wb_result,
    output logic                div_done,
    output logic                div_busy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t          state;
    div_op_t         op;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] divisor;
    logic            q_neg;
    logic            r_neg;
    logic [CW-1:0]   cnt;

    // ---------------- accept-side decode ----------------
    logic            in_valid;
    div_op_t         in_op;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic            in_signed;
    logic            in_is_rem;
    logic [XLEN-1:0] in_rs1_abs;
    logic [XLEN-1:0] in_rs2_abs;
    logic            in_div0;
    logic            in_ovf;
    logic [XLEN-1:0] in_special_res;

    assign in_valid  = dispatcher_div_inf.ctrl.instruction_valid;
    assign in_op     = dispatcher_div_inf.ctrl.div_control;
    assign in_rs1    = XLEN'(dispatcher_div_inf.rs1);
    assign in_rs2    = XLEN'(dispatcher_div_inf.rs2);
    assign in_signed = (in_op == DIV_OP_DIV) || (in_op == DIV_OP_REM);
    assign in_is_rem = (in_op == DIV_OP_REM) || (in_op == DIV_OP_REMU);

    assign in_rs1_abs = (in_signed && in_rs1[XLEN-1]) ? (~in_rs1 + 1'b1) : in_rs1;
    assign in_rs2_abs = (in_signed && in_rs2[XLEN-1]) ? (~in_rs2 + 1'b1) : in_rs2;

    // Most-negative / -1 is the only signed quotient that does not fit in XLEN bits.
    assign in_div0 = (in_rs2 == '0);
    assign in_ovf  = in_signed && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);

    always_comb begin
        in_special_res = '0;
        if (in_div0) begin
            in_special_res = in_is_rem ? in_rs1 : '1;
        end else if (in_ovf) begin
            in_special_res = in_is_rem ? '0 : in_rs1;
        end
    end

    // ---------------- one restoring step ----------------
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic            trial_ok;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] dvd_nxt;

    assign rem_sh = {rem, dvd[XLEN-1]};
    assign trial  = rem_sh - {1'b0, divisor};
    // rem < divisor always holds, so a set shifted-out bit means rem_sh already
    // exceeds any XLEN-bit divisor and the subtraction must be taken even though
    // the (XLEN+1)-bit trial looks negative.
    assign trial_ok = rem_sh[XLEN] | ~trial[XLEN];
    assign rem_nxt  = trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign dvd_nxt  = {dvd[XLEN-2:0], trial_ok};

    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;
    logic [XLEN-1:0] final_res;

    assign quo_fin   = q_neg ? (~dvd_nxt + 1'b1) : dvd_nxt;
    assign rem_fin   = r_neg ? (~rem_nxt + 1'b1) : rem_nxt;
    assign final_res = ((op == DIV_OP_REM) || (op == DIV_OP_REMU)) ? rem_fin : quo_fin;

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            div_wb_valid  <= 1'b0;
            div_wb_rd     <= '0;
            div_wb_result <= '0;
            cnt           <= '0;
        end else if (flush) begin
            state        <= IDLE;
            div_wb_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op        <= in_op;
                        div_wb_rd <= dispatcher_div_inf.rd;
                        dvd       <= in_rs1_abs;
                        divisor   <= in_rs2_abs;
                        q_neg     <= in_signed && (in_rs1[XLEN-1] ^ in_rs2[XLEN-1]);
                        r_neg     <= in_signed && in_rs1[XLEN-1];
                        rem       <= '0;
                        cnt       <= '0;
                        if (in_div0 || in_ovf) begin
                            state         <= DONE;
                            div_wb_valid  <= 1'b1;
                            div_wb_result <= in_special_res;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_nxt;
                    dvd <= dvd_nxt;
                    cnt <= cnt + 1'b1;
                    // The last step writes the signed-corrected result straight
                    // into the output register so valid rises with DONE.
                    if (cnt == CW'(XLEN-1)) begin
                        state         <= DONE;
                        div_wb_valid  <= 1'b1;
                        div_wb_result <= final_res;
                    end
                end
                DONE: begin
                    if (div_wb_ready) begin
                        state        <= RECOVER;
                        div_wb_valid <= 1'b0;
                    end
                end
                // The dispatcher still shows the finished DIV for this one cycle.
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign div_done = div_wb_valid && div_wb_ready && !flush;
    assign div_busy = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a result scoreboard and an independent reference model.
// Latency: checks 33-cycle normal and 1-cycle special-case result timing.
// Backpressure: holds div_wb_ready low in DONE and checks output stability and the done pulse.

module tb_div_unit;
    import div_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    dispatcher_div_inf_t inf;
    logic                div_wb_ready;
    logic                div_wb_valid;
    logic [4:0]          div_wb_rd;
    logic [31:0]         div_wb_result;
    logic                div_done;
    logic                div_busy;

    div_unit #(.XLEN(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .dispatcher_div_inf (inf),
        .div_wb_ready       (div_wb_ready),
        .div_wb_valid       (div_wb_valid),
        .div_wb_rd          (div_wb_rd),
        .div_wb_result      (div_wb_result),
        .div_done           (div_done),
        .div_busy           (div_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: native signed/unsigned division plus the RISC-V special cases.
    function automatic logic [31:0] model(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb_;
        sa  = a;
        sb_ = b;
        case (op)
            DIV_OP_DIVU: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            DIV_OP_REMU: model = (b == 0) ? a : a % b;
            DIV_OP_DIV: begin
                if (b == 0) model = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h8000_0000;
                else model = sa / sb_;
            end
            default: begin
                if (b == 0) model = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h0;
                else model = sa % sb_;
            end
        endcase
    endfunction

    task automatic drive(input div_op_t op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        inf.ctrl.instruction_valid = 1'b1;
        inf.ctrl.div_control       = op;
        inf.rd                     = rd;
        inf.rs1                    = a;
        inf.rs2                    = b;
    endtask

    // Called at a negedge (+1). Issues one op, waits for the result, checks
    // timing/value/handshake, and returns in the first cycle an accept may happen.
    task automatic run_op(input string tag, input div_op_t op, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input int stall, input bit stale,
                          output int acc_cyc);
        exp_t e;
        int   n;
        logic [31:0] held_res;
        drive(op, rd, a, b);
        acc_cyc = cyc;
        sb.push_back('{rd: rd, res: model(op, a, b)});
        @(negedge clk);
        if (!stale) inf.ctrl.instruction_valid = 1'b0;
        n = 0;
        while (!div_wb_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".valid"}, 64'(div_wb_valid), 64'd1);
        check({tag, ".lat"}, 64'(cyc - acc_cyc), 64'(exp_lat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".rd"}, 64'(div_wb_rd), 64'(e.rd));
            check({tag, ".res"}, 64'(div_wb_result), 64'(e.res));
        end else begin
            check({tag, ".scoreboard"}, 64'(sb.size()), 64'd1);
        end
        held_res = div_wb_result;
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                check({tag, ".stall_done"}, 64'(div_done), 64'd0);
                check({tag, ".stall_hold"}, {31'd0, div_wb_valid, div_wb_result}, {31'd0, 1'b1, held_res});
                @(negedge clk);
            end
            div_wb_ready = 1'b1;
            #1;
        end
        check({tag, ".done"}, 64'(div_done), 64'd1);
        @(negedge clk);
        check({tag, ".recover"}, {61'd0, div_done, div_busy, div_wb_valid}, {61'd0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        inf.ctrl.instruction_valid = 1'b0;
        #1;
        check({tag, ".idle"}, 64'(div_busy), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int a1;
        bit seen;

        rst          = 1'b1;
        flush        = 1'b0;
        div_wb_ready = 1'b1;
        inf          = '0;
        repeat (3) @(negedge clk);
        check("reset", {59'd0, div_wb_valid, div_done, div_busy, div_wb_rd == 5'd0, div_wb_result == 32'd0},
              {59'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        rst = 1'b0;
        @(negedge clk);
        #1;

        run_op("divu_100_7", DIV_OP_DIVU, 5'd3, 32'd100, 32'd7, 33, 0, 0, a0);
        run_op("remu_100_7", DIV_OP_REMU, 5'd4, 32'd100, 32'd7, 33, 0, 0, a0);
        run_op("div_m7_2",   DIV_OP_DIV,  5'd5, -32'sd7, 32'd2, 33, 0, 0, a0);
        run_op("rem_m7_2",   DIV_OP_REM,  5'd6, -32'sd7, 32'd2, 33, 0, 0, a0);
        run_op("div_7_m2",   DIV_OP_DIV,  5'd7, 32'd7, -32'sd2, 33, 0, 0, a0);
        run_op("rem_7_m2",   DIV_OP_REM,  5'd0, 32'd7, -32'sd2, 33, 0, 0, a0);
        run_op("div_5_0",    DIV_OP_DIV,  5'd8, 32'd5, 32'd0, 1, 0, 0, a0);
        run_op("remu_5_0",   DIV_OP_REMU, 5'd9, 32'd5, 32'd0, 1, 0, 0, a0);
        run_op("div_ovf",    DIV_OP_DIV,  5'd10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0, a0);
        run_op("rem_ovf",    DIV_OP_REM,  5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0, a0);
        run_op("divu_big",   DIV_OP_DIVU, 5'd12, 32'hFFFF_FFFE, 32'h8000_0001, 33, 0, 0, a0);

        // Backpressure with the dispatcher still presenting the op afterwards.
        div_wb_ready = 1'b0;
        run_op("stall_stale", DIV_OP_DIVU, 5'd13, 32'd1000, 32'd33, 33, 10, 1, a0);

        // Flush at counter 15: op is dropped, nothing reaches write-back.
        drive(DIV_OP_DIVU, 5'd14, 32'd50, 32'd3);
        @(negedge clk);
        inf.ctrl.instruction_valid = 1'b0;
        repeat (15) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_idle", {62'd0, div_busy, div_wb_valid}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_wb_valid) seen = 1'b1;
        end
        check("flush_no_result", 64'(seen), 64'd0);
        #1;
        run_op("divu_9_3", DIV_OP_DIVU, 5'd15, 32'd9, 32'd3, 33, 0, 0, a0);

        // Reset mid-BUSY.
        drive(DIV_OP_REMU, 5'd16, 32'd77, 32'd5);
        @(negedge clk);
        inf.ctrl.instruction_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid", {59'd0, div_wb_valid, div_done, div_busy, div_wb_rd == 5'd0, div_wb_result == 32'd0},
              {59'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        #1;

        run_op("remu_17_5", DIV_OP_REMU, 5'd17, 32'd17, 32'd5, 33, 0, 0, a0);
        run_op("remu_20_6", DIV_OP_REMU, 5'd18, 32'd20, 32'd6, 33, 0, 0, a1);
        check("b2b_spacing", 64'(a1 - a0), 64'd35);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
